// File: rtl/io_mem_read_dma.sv
// Read-side DMA ahead of conv2D: splits a read command into credit-checked memory
// bursts and returns words in order through a response FIFO. Optional perf counters: RD_DMA_PERF_CNT_EN.
module io_mem_read_dma #(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 16,
  parameter int LOGDEPTH  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] req_read_addr,
  input  logic              req_read_addr_valid,
  output logic              req_read_addr_ready,
  input  logic [31:0]       req_read_len,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [AWIDTH-1:0] mem_req_addr,
  output logic [31:0]       mem_req_len,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic [DWIDTH-1:0] mem_resp_data,
  input  logic              mem_resp_valid,
  output logic              busy
`ifdef RD_DMA_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       beats_out
`endif
);

  localparam int                DEPTH       = 1 << LOGDEPTH;
  localparam logic [31:0]       MAX_BURST_W = 32'(MAX_BURST);
  localparam logic [31:0]       BEAT_BYTES  = 32'(DWIDTH / 8);
  localparam logic [LOGDEPTH:0] FULL_COUNT  = (LOGDEPTH + 1)'(DEPTH);
  localparam logic [33:0]       DEPTH_W     = 34'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state, state_next;
  logic [AWIDTH-1:0]   cur_addr;
  logic [31:0]         remaining;
  logic [31:0]         outstanding;
  logic [31:0]         burst_len;
  logic [33:0]         committed;
  logic                credit_ok;
  logic                cmd_fire;
  logic                mem_fire;
  logic                resp_accept;
  logic                enq;
  logic                deq;

  logic [DWIDTH-1:0]   fifo_mem [DEPTH];
  logic [LOGDEPTH-1:0] wr_ptr;
  logic [LOGDEPTH-1:0] rd_ptr;
  logic [LOGDEPTH:0]   fifo_count;

  // Every word already in the FIFO or still owed by memory holds a slot, so a burst
  // is only requested once all of its beats are guaranteed a place to land.
  assign burst_len   = (remaining > MAX_BURST_W) ? MAX_BURST_W : remaining;
  assign committed   = 34'(fifo_count) + 34'(outstanding) + 34'(burst_len);
  assign credit_ok   = (committed <= DEPTH_W);

  assign cmd_fire    = req_read_addr_valid && req_read_addr_ready;
  assign mem_fire    = (state == ISSUE) && credit_ok && mem_req_ready;
  assign resp_accept = mem_resp_valid && (outstanding != 32'd0);
  assign deq         = rdata_valid && rdata_ready;
  assign enq         = resp_accept && ((fifo_count != FULL_COUNT) || deq);

  assign req_read_addr_ready = (state == IDLE);
  assign busy                = (state != IDLE);
  assign rdata_valid         = (fifo_count != '0);
  assign rdata               = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request fields only change on a fire and credit can only grow while waiting,
  // so a raised request stays stable until memory takes it.
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_len   = '0;
    case (state)
      IDLE: begin
        if (cmd_fire && (req_read_len != 32'd0)) state_next = ISSUE;
      end
      ISSUE: begin
        mem_req_valid = credit_ok;
        mem_req_addr  = cur_addr;
        mem_req_len   = burst_len;
        if (credit_ok && mem_req_ready && (remaining == burst_len)) state_next = DRAIN;
      end
      DRAIN: begin
        if ((outstanding == 32'd0) || ((outstanding == 32'd1) && resp_accept)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr    <= '0;
      remaining   <= '0;
      outstanding <= '0;
    end else begin
      if ((state == IDLE) && cmd_fire && (req_read_len != 32'd0)) begin
        cur_addr  <= req_read_addr;
        remaining <= req_read_len;
      end else if (mem_fire) begin
        cur_addr  <= cur_addr + AWIDTH'(burst_len * BEAT_BYTES);
        remaining <= remaining - burst_len;
      end
      outstanding <= outstanding + (mem_fire ? burst_len : 32'd0) - (resp_accept ? 32'd1 : 32'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= mem_resp_data;
  end

`ifdef RD_DMA_PERF_CNT_EN
  // Counters restart with each accepted command and stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      beats_out    <= '0;
    end else if (cmd_fire) begin
      stall_cycles <= '0;
      beats_out    <= '0;
    end else begin
      if ((state == ISSUE) && !credit_ok && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (deq && (beats_out != 32'hFFFF_FFFF))
        beats_out <= beats_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_io_mem_read_dma.sv
// Randomized bench for io_mem_read_dma: a behavioural memory plus a word/burst
// scoreboard built from the command list. Set RD_DMA_PERF_CNT_EN to also check the counters.
module tb_io_mem_read_dma;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
  } burst_t;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_read_addr = '0;
  logic        req_read_addr_valid = 1'b0;
  logic        req_read_addr_ready;
  logic [31:0] req_read_len = '0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_len;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_valid = 1'b0;
  logic        busy;
`ifdef RD_DMA_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] beats_out;
`endif

  io_mem_read_dma #(
    .AWIDTH(32), .DWIDTH(32), .MAX_BURST(16), .LOGDEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_read_addr(req_read_addr), .req_read_addr_valid(req_read_addr_valid),
    .req_read_addr_ready(req_read_addr_ready), .req_read_len(req_read_len),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid),
    .busy(busy)
`ifdef RD_DMA_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .beats_out(beats_out)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] exp_words[$];
  burst_t      exp_bursts[$];
  beat_t       resp_q[$];

  int num_checks = 0;
  int num_errors = 0;
  int cyc = 0;
  int last_rdy = 0;
  int resp_lat = 2;
  int rdata_mode = 1;
  int memrdy_mode = 1;
  bit exp_busy = 1'b0;
  int beats_left = 0;
  int bursts_fired = 0;
  int words_out = 0;
  int inflight = 0;
  bit prev_pend = 1'b0;
  logic [31:0] prev_addr, prev_len;

  // Memory contents: an odd multiplier keeps every address's word distinct.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelCommand(input logic [31:0] addr, input logic [31:0] len);
    logic [31:0] a;
    logic [31:0] r;
    logic [31:0] b;
    for (int i = 0; i < int'(len); i++) exp_words.push_back(memWord(addr + 32'(4 * i)));
    a = addr;
    r = len;
    while (r != 0) begin
      b = (r > 32'd16) ? 32'd16 : r;
      exp_bursts.push_back('{addr: a, len: b});
      a = a + 4 * b;
      r = r - b;
    end
  endtask

  task automatic clearModel();
    exp_words.delete();
    exp_bursts.delete();
    resp_q.delete();
    exp_busy   = 1'b0;
    beats_left = 0;
    prev_pend  = 1'b0;
    inflight   = 0;
    last_rdy   = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder and consumer/ready drivers, updated just after each edge.
  initial begin
    beat_t b;
    forever begin
      @(posedge clk);
      #1;
      rdata_ready   = (rdata_mode == 2) ? ($urandom % 4 != 0) : (rdata_mode == 1);
      mem_req_ready = (memrdy_mode == 2) ? ($urandom % 3 != 0) : (memrdy_mode == 1);
      if (!rst) begin
        mem_resp_valid = 1'b0;
        resp_q.delete();
      end else if (resp_q.size() != 0 && resp_q[0].rdy <= cyc) begin
        b = resp_q.pop_front();
        mem_resp_valid = 1'b1;
        mem_resp_data  = memWord(b.addr);
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
      end
    end
  end

  // Scoreboard: samples every cycle at the falling edge.
  initial begin
    bit nb;
    int lat;
    int rdy;
    burst_t eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("busy", busy, exp_busy);
        checkOutput("cmd_ready", req_read_addr_ready, !exp_busy);
        nb = exp_busy;
        if (mem_resp_valid && beats_left > 0) begin
          beats_left--;
          if (beats_left == 0) nb = 1'b0;
        end
        if (req_read_addr_valid && req_read_addr_ready && req_read_len != 0) begin
          modelCommand(req_read_addr, req_read_len);
          beats_left = int'(req_read_len);
          nb = 1'b1;
        end
        if (prev_pend) begin
          checkOutput("mem_req_hold_valid", mem_req_valid, 1'b1);
          checkOutput("mem_req_hold_addr", mem_req_addr, prev_addr);
          checkOutput("mem_req_hold_len", mem_req_len, prev_len);
        end
        prev_pend = 1'b0;
        if (mem_req_valid) begin
          if (mem_req_ready) begin
            bursts_fired++;
            checkOutput("burst_expected", exp_bursts.size() != 0, 1'b1);
            if (exp_bursts.size() != 0) begin
              eb = exp_bursts.pop_front();
              checkOutput("burst_addr", mem_req_addr, eb.addr);
              checkOutput("burst_len", mem_req_len, eb.len);
            end
            checkOutput("credit", (inflight + int'(mem_req_len)) <= DEPTH, 1'b1);
            inflight += int'(mem_req_len);
            lat = (resp_lat == 0) ? $urandom_range(1, 4) : resp_lat;
            for (int i = 0; i < int'(mem_req_len) && i < 64; i++) begin
              rdy = (last_rdy + 1 > cyc + lat) ? last_rdy + 1 : cyc + lat;
              resp_q.push_back('{addr: mem_req_addr + 32'(4 * i), rdy: rdy});
              last_rdy = rdy;
            end
          end else begin
            prev_pend = 1'b1;
            prev_addr = mem_req_addr;
            prev_len  = mem_req_len;
          end
        end
        if (rdata_valid && rdata_ready) begin
          words_out++;
          inflight--;
          checkOutput("rdata_expected", exp_words.size() != 0, 1'b1);
          if (exp_words.size() != 0) checkOutput("rdata", rdata, exp_words.pop_front());
        end
        exp_busy = nb;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    @(posedge clk);
    #1;
    req_read_addr       = addr;
    req_read_len        = len;
    req_read_addr_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req_read_addr_ready) begin
        got = 1'b1;
        break;
      end
      waited++;
    end
    checkOutput("cmd_accept", got, 1'b1);
    @(posedge clk);
    #1;
    req_read_addr_valid = 1'b0;
    req_read_addr       = $urandom;
    req_read_len        = $urandom;
  endtask

  task automatic waitDrain(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #1;
      if (exp_words.size() == 0 && exp_bursts.size() == 0 && !exp_busy) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_done", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0;
    int w0;
    int waited;
    bit got;
    logic [31:0] a;
    logic [31:0] l;

    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_cmd_ready", req_read_addr_ready, 1'b1);
    checkOutput("reset_rdata_valid", rdata_valid, 1'b0);
    checkOutput("reset_mem_req_valid", mem_req_valid, 1'b0);
    checkOutput("reset_mem_req_addr", mem_req_addr, 32'h0);
    checkOutput("reset_mem_req_len", mem_req_len, 32'h0);
    checkOutput("reset_busy", busy, 1'b0);
    clearModel();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    $display("[TB] single burst, len 9");
    b0 = bursts_fired;
    applyStimulus(32'h100, 32'd9, waited);
    waitDrain(500);
    checkOutput("len9_bursts", bursts_fired - b0, 1);

    $display("[TB] three bursts, len 40");
    b0 = bursts_fired;
    applyStimulus(32'h0, 32'd40, waited);
    waitDrain(1000);
    checkOutput("len40_bursts", bursts_fired - b0, 3);

    $display("[TB] credit stall, len 48 with consumer held off");
    rdata_mode = 0;
    @(posedge clk);
    b0 = bursts_fired;
    applyStimulus(32'h1000, 32'd48, waited);
    repeat (100) @(negedge clk);
    #1;
    checkOutput("stall_one_burst", bursts_fired - b0, 1);
    checkOutput("stall_req_blocked", mem_req_valid, 1'b0);
    checkOutput("stall_fifo_holds", rdata_valid, 1'b1);
    rdata_mode = 1;
    waitDrain(2000);
    checkOutput("stall_total_bursts", bursts_fired - b0, 3);
`ifdef RD_DMA_PERF_CNT_EN
    checkOutput("perf_stall_seen", stall_cycles > 32'd50, 1'b1);
    checkOutput("perf_beats_48", beats_out, 32'd48);
`endif

    $display("[TB] zero-length command");
    b0 = bursts_fired;
    applyStimulus(32'h5000, 32'd0, waited);
    checkOutput("len0_one_cycle", waited, 0);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("len0_no_bursts", bursts_fired - b0, 0);
    checkOutput("len0_busy", busy, 1'b0);

    $display("[TB] reset mid-command");
    w0 = words_out;
    applyStimulus(32'h3000, 32'd32, waited);
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (words_out - w0 >= 5) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("midreset_progress", got, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset_rdata_valid", rdata_valid, 1'b0);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_mem_req_valid", mem_req_valid, 1'b0);
    clearModel();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    b0 = bursts_fired;
    applyStimulus(32'h200, 32'd4, waited);
    waitDrain(500);
    checkOutput("after_reset_bursts", bursts_fired - b0, 1);

    $display("[TB] address wrap");
    b0 = bursts_fired;
    applyStimulus(32'hFFFF_FFF8, 32'd4, waited);
    waitDrain(500);
    checkOutput("wrap_bursts", bursts_fired - b0, 1);
`ifdef RD_DMA_PERF_CNT_EN
    checkOutput("perf_beats_wrap", beats_out, 32'd4);
`endif

    $display("[TB] randomized commands");
    rdata_mode  = 2;
    memrdy_mode = 2;
    resp_lat    = 0;
    for (int n = 0; n < 30; n++) begin
      a = ($urandom % 5 == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFC)) : ($urandom & 32'hFFFF_FFFC);
      l = ($urandom % 8 == 0) ? 32'd0 : 32'($urandom_range(1, 50));
      applyStimulus(a, l, waited);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    waitDrain(6000);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
